// File: rtl/pipe_acc16_core.sv
// rtl/pipe_acc16_core.sv - 16-bit accumulator processor, 3-stage IF/ID/EX pipeline
module pipe_acc16_core #(
   parameter int ADDR_W     = 10,
   parameter int IMEM_DEPTH = 1024,
   parameter int DMEM_DEPTH = 1024
) (
   input  logic              clk1,
   input  logic              rst_n,
   output logic [15:0]       acc,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   localparam logic [5:0] OP_LDA  = 6'h0A;
   localparam logic [5:0] OP_LDI  = 6'h0B;
   localparam logic [5:0] OP_STA  = 6'h0C;
   localparam logic [5:0] OP_ADD  = 6'h2D;
   localparam logic [5:0] OP_SUB  = 6'h2E;
   localparam logic [5:0] OP_AND  = 6'h2F;
   localparam logic [5:0] OP_OR   = 6'h30;
   localparam logic [5:0] OP_XOR  = 6'h31;
   localparam logic [5:0] OP_ADDI = 6'h20;
   localparam logic [5:0] OP_JMP  = 6'h38;
   localparam logic [5:0] OP_JZ   = 6'h39;
   localparam logic [5:0] OP_JN   = 6'h3A;
   localparam logic [5:0] OP_HLT  = 6'h3F;

   localparam logic [15:0] NOP_WORD = 16'h0000;

   // Memories are preloaded externally and never reset.
   logic [15:0] ins_mem  [0:IMEM_DEPTH-1];
   logic [15:0] data_mem [0:DMEM_DEPTH-1];

   // IF/ID and ID/EX instruction registers.
   logic [15:0] if_ir;
   logic [15:0] ex_ir;

   logic [5:0]        ex_op;
   logic [9:0]        ex_opd;
   logic [ADDR_W-1:0] ex_addr;
   logic [15:0]       ex_imm;
   logic [15:0]       dmem_rd;
   logic [15:0]       acc_nxt;
   logic              st_we;
   logic              take;
   logic              hlt;

   assign ex_op   = ex_ir[15:10];
   assign ex_opd  = ex_ir[9:0];
   assign ex_addr = ADDR_W'(ex_opd);
   assign ex_imm  = {6'b0, ex_opd};

   // EX stage: data read, ALU, store enable and branch/halt resolution.
   always_comb begin
      dmem_rd = data_mem[ex_addr];
      acc_nxt = acc;
      st_we   = 1'b0;
      take    = 1'b0;
      hlt     = 1'b0;
      case (ex_op)
         OP_LDA:  acc_nxt = dmem_rd;
         OP_LDI:  acc_nxt = ex_imm;
         OP_STA:  st_we   = 1'b1;
         OP_ADD:  acc_nxt = acc + dmem_rd;
         OP_SUB:  acc_nxt = acc - dmem_rd;
         OP_AND:  acc_nxt = acc & dmem_rd;
         OP_OR:   acc_nxt = acc | dmem_rd;
         OP_XOR:  acc_nxt = acc ^ dmem_rd;
         OP_ADDI: acc_nxt = acc + ex_imm;
         OP_JMP:  take    = 1'b1;
         OP_JZ:   take    = (acc == 16'h0000);
         OP_JN:   take    = acc[15];
         OP_HLT:  hlt     = 1'b1;
         default: ;
      endcase
   end

   // Pipeline advance; a taken branch or HLT squashes both younger stages.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         pc     <= '0;
         if_ir  <= NOP_WORD;
         ex_ir  <= NOP_WORD;
         acc    <= 16'h0000;
         halted <= 1'b0;
      end else if (!halted) begin
         acc <= acc_nxt;
         if (take) begin
            pc    <= ex_addr;
            if_ir <= NOP_WORD;
            ex_ir <= NOP_WORD;
         end else if (hlt) begin
            halted <= 1'b1;
            if_ir  <= NOP_WORD;
            ex_ir  <= NOP_WORD;
         end else begin
            pc    <= pc + ADDR_W'(1);
            if_ir <= ins_mem[pc];
            ex_ir <= if_ir;
         end
      end
   end

   // STA write; ex_ir is NOP during reset and after halt, so no gating needed.
   always_ff @(posedge clk1) begin
      if (st_we) data_mem[ex_addr] <= acc;
   end

endmodule

// File: tb/tb_pipe_acc16_core.sv
// tb/tb_pipe_acc16_core.sv - randomized self-checking bench against an ISA-level model
module tb_pipe_acc16_core;

   logic        clk1 = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] acc;
   logic [9:0]  pc;
   logic        halted;

   int n_checks = 0;
   int n_fail   = 0;

   // Architectural model: next instruction to execute, fetch pc, refill bubbles.
   logic [15:0] m_imem [1024];
   logic [15:0] m_dmem [1024];
   logic [9:0]  m_pc;
   logic [9:0]  m_fpc;
   logic [15:0] m_acc;
   int          m_bub;
   bit          m_halted;

   bit [5:0] ops [16];

   pipe_acc16_core #(.ADDR_W(10), .IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) dut (
      .clk1   (clk1),
      .rst_n  (rst_n),
      .acc    (acc),
      .pc     (pc),
      .halted (halted)
   );

   always #5 clk1 = ~clk1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] enc(input logic [5:0] op, input logic [9:0] opd);
      return {op, opd};
   endfunction

   task automatic set_i(input int a, input logic [15:0] w);
      dut.ins_mem[a] = w;
      m_imem[a] = w;
   endtask

   task automatic set_d(input int a, input logic [15:0] w);
      dut.data_mem[a] = w;
      m_dmem[a] = w;
   endtask

   task automatic clear_mem;
      for (int i = 0; i < 1024; i++) begin
         set_i(i, 16'h0000);
         set_d(i, 16'h0000);
      end
   endtask

   task automatic model_init;
      m_pc = '0; m_fpc = '0; m_acc = '0; m_bub = 2; m_halted = 0;
   endtask

   // One clock of the machine: either a refill bubble or one instruction retired.
   task automatic model_step;
      logic [15:0] ins, d, imm;
      logic [5:0]  op;
      logic [9:0]  a;
      bit          taken;
      if (m_halted) return;
      if (m_bub > 0) begin
         m_bub--;
         m_fpc = m_fpc + 10'd1;
         return;
      end
      ins = m_imem[m_pc]; op = ins[15:10]; a = ins[9:0];
      d = m_dmem[a]; imm = {6'b0, a}; taken = 0;
      case (op)
         6'h0A: m_acc = d;
         6'h0B: m_acc = imm;
         6'h0C: m_dmem[a] = m_acc;
         6'h2D: m_acc = m_acc + d;
         6'h2E: m_acc = m_acc - d;
         6'h2F: m_acc = m_acc & d;
         6'h30: m_acc = m_acc | d;
         6'h31: m_acc = m_acc ^ d;
         6'h20: m_acc = m_acc + imm;
         6'h38: taken = 1;
         6'h39: taken = (m_acc == 0);
         6'h3A: taken = m_acc[15];
         6'h3F: m_halted = 1;
         default: ;
      endcase
      if (m_halted) return;
      if (taken) begin
         m_pc = a; m_fpc = a; m_bub = 2;
      end else begin
         m_pc = m_pc + 10'd1; m_fpc = m_fpc + 10'd1;
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk1);
         model_step();
         #1;
         check("acc", acc, m_acc);
         check("pc", pc, m_fpc);
         check("halted", halted, m_halted);
      end
   endtask

   // Asynchronous assert between edges, immediate check, release on a falling edge.
   task automatic do_reset(input string tag);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      model_init();
      check({tag, "_rst_pc"}, pc, 0);
      check({tag, "_rst_acc"}, acc, 0);
      check({tag, "_rst_halted"}, halted, 0);
   endtask

   task automatic release_reset;
      @(negedge clk1);
      rst_n = 1'b1;
   endtask

   task automatic rand_prog;
      bit [5:0] op;
      logic [9:0] opd;
      clear_mem();
      for (int i = 0; i < 32; i++) begin
         op  = ops[$urandom_range(0, 15)];
         opd = (op == 6'h0B || op == 6'h20) ? 10'($urandom) : 10'($urandom_range(0, 31));
         set_i(i, enc(op, opd));
         set_d(i, 16'($urandom));
      end
   endtask

   initial begin
      ops = '{6'h0A, 6'h0B, 6'h0C, 6'h2D, 6'h2E, 6'h2F, 6'h30, 6'h31,
              6'h20, 6'h38, 6'h39, 6'h3A, 6'h3F, 6'h00, 6'h15, 6'h27};
      #2;

      // Pipeline latency: LDA 0; ADD 1
      do_reset("t1");
      clear_mem();
      set_i(0, 16'h2800); set_i(1, 16'hB401);
      set_d(0, 16'd0); set_d(1, 16'd2); set_d(2, 16'd3);
      release_reset();
      step(3);
      check("t1_acc_e3", acc, 16'd0);
      step(1);
      check("t1_acc_e4", acc, 16'd2);
      step(3);

      // Store then load back-to-back, no stall
      do_reset("t2");
      clear_mem();
      set_i(0, enc(6'h0B, 10'd5)); set_i(1, enc(6'h0C, 10'd7));
      set_i(2, enc(6'h0A, 10'd7)); set_i(3, enc(6'h2D, 10'd7));
      release_reset();
      step(6);
      check("t2_acc_e6", acc, 16'd10);
      check("t2_mem7", dut.data_mem[7], 16'd5);

      // Taken JZ: two bubbles, squashed LDI 1 / LDI 2
      do_reset("t3");
      clear_mem();
      set_i(0, enc(6'h0B, 10'd0)); set_i(1, enc(6'h39, 10'd10));
      set_i(2, enc(6'h0B, 10'd1)); set_i(3, enc(6'h0B, 10'd2));
      set_i(10, enc(6'h0B, 10'd9));
      release_reset();
      step(4);
      check("t3_pc_target", pc, 10'd10);
      step(2);
      check("t3_acc_bubble", acc, 16'd0);
      step(1);
      check("t3_acc_e7", acc, 16'd9);
      step(3);

      // Not-taken JZ: no penalty
      do_reset("t4");
      clear_mem();
      set_i(0, enc(6'h0B, 10'd3)); set_i(1, enc(6'h39, 10'd10));
      set_i(2, enc(6'h20, 10'd1));
      release_reset();
      step(5);
      check("t4_acc_e5", acc, 16'd4);

      // HLT freezes pc and acc
      do_reset("t5");
      clear_mem();
      set_i(0, enc(6'h0B, 10'd7)); set_i(1, enc(6'h3F, 10'd0));
      set_i(2, enc(6'h0B, 10'd1));
      release_reset();
      step(4);
      check("t5_halted", halted, 1'b1);
      for (int k = 0; k < 10; k++) begin
         step(1);
         check("t5_pc_frozen", pc, 10'd3);
         check("t5_acc_held", acc, 16'd7);
      end

      // PC wrap 1023 -> 0
      do_reset("t6");
      clear_mem();
      set_i(0, enc(6'h38, 10'd1022));
      set_i(1022, enc(6'h0B, 10'd5)); set_i(1023, enc(6'h20, 10'd1));
      release_reset();
      step(12);

      // Random programs, including a mid-program asynchronous reset
      for (int r = 0; r < 6; r++) begin
         do_reset("rnd");
         rand_prog();
         release_reset();
         step(60 + $urandom_range(0, 60));
         if (r % 2 == 1) begin
            do_reset("rnd_mid");
            release_reset();
            step(80);
         end
         for (int i = 0; i < 32; i++) check("rnd_dmem", dut.data_mem[i], m_dmem[i]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_acc16_core.md
Name: pipe_acc16_core

Overview:
- 16-bit, single-accumulator processor with a 3-stage pipeline: IF, ID, EX.
- Contains its own word-addressed instruction memory `ins_mem` and data memory `data_mem`, both 16 bits wide.
- Benches preload both memories by hierarchical assignment.
- Top-level compute block of the design; no external bus.

Parameters:
- ADDR_W, 10, address width of PC and data addresses.
- IMEM_DEPTH, 1024, number of `ins_mem` words.
- DMEM_DEPTH, 1024, number of `data_mem` words.

Ports:
- clk1  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- acc  output  16  current accumulator value.
- pc  output  ADDR_W  current fetch PC.
- halted  output  1  high once HLT has executed.

Behaviour:
- Instruction format:
  - [15:10] opcode, [9:0] operand.
  - Operand is a data address `a` or a zero-extended immediate `imm`.
- Opcodes (any other opcode executes as NOP):
  - 0x00 NOP.
  - 0x0A LDA a: acc <= data_mem[a].
  - 0x0B LDI: acc <= {6'b0, imm}.
  - 0x0C STA a: data_mem[a] <= acc.
  - 0x2D ADD a: acc <= acc + data_mem[a].
  - 0x2E SUB a: acc <= acc - data_mem[a].
  - 0x2F AND a, 0x30 OR a, 0x31 XOR a: bitwise with data_mem[a].
  - 0x20 ADDI: acc <= acc + imm.
  - 0x38 JMP a: PC <= a.
  - 0x39 JZ a: jump if acc == 0.
  - 0x3A JN a: jump if acc[15] == 1.
  - 0x3F HLT.
- Arithmetic is modulo 2^16; there are no carry or overflow flags.
- Encoding examples: 16'h2800 = LDA 0; 16'hB401 = ADD 1.
- Stages:
  - IF: IR <= ins_mem[PC]; PC <= PC+1. PC wraps from 1023 to 0.
  - ID: register opcode and operand into ID/EX.
  - EX: combinational data_mem read, ALU, then at the clock edge the acc write, data_mem write (STA) and branch resolution.
- Hazards:
  - acc and data_mem are read and written only in EX, so there are no data hazards and no forwarding or stalls.
  - Back-to-back STA then LDA to the same address must return the stored value.
- Taken branch: PC <= target; instructions in IF/ID and ID/EX become NOPs. Penalty is 2 bubbles.
- Not-taken branch: no penalty.
- HLT:
  - On EX of HLT: halted <= 1, the younger pipeline contents are squashed, and PC freezes.
  - acc and data_mem then hold until reset.
- Reset (asynchronous, any time including mid-execution):
  - PC = 0, acc = 0, halted = 0.
  - All pipeline IRs = NOP (16'h0000).
  - Memories are not reset.
- Timing:
  - The first instruction fetched after reset release updates acc at the 3rd rising edge.
  - Throughput is thereafter 1 instruction/cycle.
- `acc` and `pc` outputs are register values, not combinational next-state.

Test Plan:
- Preload ins_mem[0] = 2800, ins_mem[1] = B401, data_mem[0] = 0, data_mem[1] = 2, data_mem[2] = 3. Release reset. -> acc = 0 after edge 3, acc = 2 after edge 4.
- Program LDI 5; STA 7; LDA 7; ADD 7 -> data_mem[7] = 5; final acc = 10 with no stall cycles (4 instructions complete by edge 6).
- Program LDI 0; JZ 10; LDI 1; LDI 2; with ins_mem[10] = LDI 9 -> LDI 1 and LDI 2 never write acc; acc = 9; 2 bubbles observed.
- Program LDI 3; JZ 10; ADDI 1 -> branch not taken; acc = 4; no bubbles.
- Program LDI 7; HLT; LDI 1 -> halted = 1; acc stays 7; pc constant for 10 further cycles.
- Assert rst_n low mid-program, asynchronously between edges -> pc = 0, acc = 0, halted = 0 immediately. After release, the program re-runs from address 0.
